// File: rtl/mem_ctl_if.sv
// External memory bus between mem_ctl (master) and the memory (slave).
// The master holds a request until the memory acknowledges it.
interface mem_ctl_if;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/mem_ctl.sv
// Memory controller: turns decoder read/write strobes into a held bus request.
// Writes are posted, reads return data with a mem_ready pulse, and stalled requests time out.
module mem_ctl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        mem_busy,
  output logic        mem_ready,
  output logic [15:0] rdata,
  output logic        bus_err,
  mem_ctl_if.master   bus
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rdata_q <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // Write has priority when both strobes are high.
        if (ram_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = 1'b1;
          cnt_d   = 8'd0;
          state_d = StWr;
        end else if (ram_read) begin
          addr_d  = addr;
          we_d    = 1'b0;
          cnt_d   = 8'd0;
          state_d = StRd;
        end
      end
      StRd: begin
        if (bus.bus_ack) begin
          rdata_d = bus.bus_rdata;
          state_d = StDone;
        end else if (cnt_q == TimeoutCnt) begin
          rdata_d = 16'hFFFF;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWr: begin
        if (bus.bus_ack) begin
          state_d = StIdle;
        end else if (cnt_q == TimeoutCnt) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request and status are decoded from state so reset drops them without a clock edge.
  assign mem_busy      = (state_q == StRd) || (state_q == StWr);
  assign mem_ready     = (state_q == StDone);
  assign rdata         = rdata_q;
  assign bus_err       = err_q;
  assign bus.bus_req   = mem_busy;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/mem_ctl.md
MEM_CTL -- requirements
Module: mem_ctl

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 255, meaning maximum cycles bus_req may wait for bus_ack before abort (range 1..255).

Interface
REQ-002 SHALL have clk input, 1 bit, the single clock; all state updates on posedge clk.
REQ-003 SHALL have rst_n input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have ram_read input, 1 bit, the decoder read strobe.
REQ-005 SHALL have ram_write input, 1 bit, the decoder write strobe.
REQ-006 SHALL have addr input, 16 bits, the CPU-side address.
REQ-007 SHALL have wdata input, 16 bits, the CPU-side write data.
REQ-008 SHALL have mem_busy output, 1 bit, high while a transaction is outstanding.
REQ-009 SHALL have mem_ready output, 1 bit, a one-cycle pulse signalling that read data is valid.
REQ-010 SHALL have rdata output, 16 bits, the read data, held until the next read completes.
REQ-011 SHALL have bus_err output, 1 bit, a one-cycle pulse on timeout abort.
REQ-012 SHALL have bus_req output, 1 bit, the external request, held until bus_ack.
REQ-013 SHALL have bus_we output, 1 bit, 1 = write, 0 = read, valid while bus_req is high.
REQ-014 SHALL have bus_addr and bus_wdata outputs, 16 bits each, the latched address and data.
REQ-015 SHALL have bus_rdata input, 16 bits, and bus_ack input, 1 bit, from the memory.

Function
REQ-016 SHALL implement states IDLE, RD, WR, DONE; all outputs SHALL be registered or decoded from state only, with no combinational path from ram_read/ram_write to any output.
REQ-017 In IDLE with ram_write=1 at posedge: latch addr/wdata, set bus_we=1, bus_req=1, go to WR; write SHALL win if ram_read and ram_write are both high.
REQ-018 In IDLE with ram_read=1 and ram_write=0 at posedge: latch addr, set bus_we=0, bus_req=1, go to RD.
REQ-019 mem_busy SHALL be 1 exactly in RD and WR; writes are posted, so the decoder advances immediately and stalls on mem_busy only at its next memory access.
REQ-020 In RD with bus_ack=1 at posedge: capture bus_rdata into rdata, drop bus_req, go to DONE.
REQ-021 In WR with bus_ack=1 at posedge: drop bus_req, go directly to IDLE; no mem_ready is issued for writes.
REQ-022 In DONE, mem_ready=1 and mem_busy=0 for exactly one cycle, then unconditionally go to IDLE.
REQ-023 ram_read/ram_write SHALL be ignored in RD, WR and DONE; a strobe still high on return to IDLE SHALL be accepted as a new request.
REQ-024 Latency: a read with bus_ack on the first RD cycle SHALL give mem_ready 2 cycles after the accept edge; each additional wait cycle adds 1.
REQ-025 Wait counter: 8 bits, cleared on accept, incremented each RD/WR cycle without ack; when it reaches TIMEOUT, the next edge SHALL abort.
REQ-026 Read abort SHALL load rdata=16'hFFFF, pulse bus_err, drop bus_req and go to DONE; write abort SHALL pulse bus_err, drop bus_req and go to IDLE.
REQ-027 bus_ack received in IDLE or DONE SHALL be ignored.
REQ-028 bus_addr, bus_wdata and bus_we SHALL stay stable from accept until the state leaves RD/WR.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, bus_req=0, bus_we=0, mem_busy=0, mem_ready=0, bus_err=0, rdata=0, bus_addr=0, bus_wdata=0 and counter=0, including mid-transaction.
REQ-030 After rst_n rises, the first accept SHALL occur no earlier than the first posedge with rst_n=1.

Verification
REQ-031 Read, zero wait: ram_read with addr=0x1234 and bus_ack on the first RD cycle with bus_rdata=0xBEEF -> mem_busy high for 1 cycle, then mem_ready pulse 1 cycle with rdata=0xBEEF.
REQ-032 Posted write with 3 wait cycles: ram_write with addr=0x0010 and wdata=0x55AA -> bus_req/bus_we held 4 cycles with stable addr/data, mem_busy 4 cycles, no mem_ready.
REQ-033 Back-to-back: write then read strobe during WR -> read accepted only on the first IDLE edge; bus_addr changes only after WR ends.
REQ-034 Timeout with TIMEOUT=4 and no ack on a read -> abort after 5 RD cycles, bus_err pulse, mem_ready pulse, rdata=0xFFFF.
REQ-035 Reset mid-RD: rst_n low during RD -> bus_req and mem_busy drop without a clock edge, and no mem_ready follows.
REQ-036 Simultaneous ram_read and ram_write in IDLE -> WR entered with bus_we=1.
